// File: rtl/weight_sram_loader_if.sv
// ---------------------------------------------------------------------------
// weight_sram_loader_if
//   Bundles the weight stream handshake, load control and SRAM write-side
//   signals of the weight SRAM loader.
//   master : upstream side (drives start/numKern/inData/inValid, observes all)
//   slave  : the loader itself
//   Signals:
//     start, numKern[4:0]          load request and kernel count
//     inData[7:0], inValid, inReady weight byte stream handshake
//     sramDataIn[7:0], sramKernAddr[3:0], sramPixAddr[5:0],
//     sramCS, sramWE, sramRD, sramIfmaps, sramPixels   SRAM write port
//     busy, done, wordCount[8:0]   status
// ---------------------------------------------------------------------------
interface weight_sram_loader_if;
  logic       start;
  logic [4:0] numKern;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic [7:0] sramDataIn;
  logic [3:0] sramKernAddr;
  logic [5:0] sramPixAddr;
  logic       sramCS;
  logic       sramWE;
  logic       sramRD;
  logic       sramIfmaps;
  logic       sramPixels;
  logic       busy;
  logic       done;
  logic [8:0] wordCount;

  modport master (
    output start, numKern, inData, inValid,
    input  inReady, sramDataIn, sramKernAddr, sramPixAddr, sramCS, sramWE,
           sramRD, sramIfmaps, sramPixels, busy, done, wordCount
  );

  modport slave (
    input  start, numKern, inData, inValid,
    output inReady, sramDataIn, sramKernAddr, sramPixAddr, sramCS, sramWE,
           sramRD, sramIfmaps, sramPixels, busy, done, wordCount
  );
endinterface

// File: rtl/weight_sram_loader.sv
// ---------------------------------------------------------------------------
// weight_sram_loader
//   Accepts a stream of 8-bit kernel weights over valid/ready and writes them
//   kernel-major into the weight SRAM (pixel 0..PIXELS-1 of kernel 0, then
//   kernel 1, ...). Pulses done once the last write has been presented.
//   Ports:
//     Clk  : clock, rising edge
//     Rst  : synchronous active-high reset
//     bus  : weight_sram_loader_if.slave (stream, SRAM write port, status)
//   Parameters:
//     KERNELS : kernel rows in the SRAM, also the maximum load count (<=16)
//     PIXELS  : weights per kernel (<=64)
// ---------------------------------------------------------------------------
module weight_sram_loader #(
  parameter int KERNELS = 16,
  parameter int PIXELS  = 25
) (
  input  logic                  Clk,
  input  logic                  Rst,
  weight_sram_loader_if.slave   bus
);

  localparam logic [4:0] KERN_MAX = 5'(KERNELS);
  localparam logic [5:0] PIX_LAST = 6'(PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [4:0] r_num;       // latched (clamped) kernel count
  logic [4:0] r_kern;      // kernel of the next accepted byte
  logic [5:0] r_pix;       // pixel of the next accepted byte
  logic [8:0] r_word;
  logic [7:0] r_data;
  logic [3:0] r_kaddr;
  logic [5:0] r_paddr;
  logic       r_we;

  logic       w_start;
  logic       w_xfer;
  logic       w_last;
  logic [4:0] w_num_clamped;

  assign w_start = (r_state == S_IDLE) && bus.start;
  assign w_xfer  = (r_state == S_LOAD) && bus.inValid;
  assign w_last  = w_xfer && (r_kern == r_num - 5'd1) && (r_pix == PIX_LAST);

  // A count of zero or anything beyond the SRAM depth means "fill it all".
  assign w_num_clamped = ((bus.numKern == 5'd0) || (bus.numKern > KERN_MAX))
                         ? KERN_MAX : bus.numKern;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_LOAD;
      S_LOAD:  if (w_last)  w_state_next = S_FLUSH;
      S_FLUSH: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counters and the registered SRAM write port. The strobe is simply the
  // transfer delayed by one cycle, so a reset on the transfer edge drops it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_num   <= 5'd0;
      r_kern  <= 5'd0;
      r_pix   <= 6'd0;
      r_word  <= 9'd0;
      r_data  <= 8'd0;
      r_kaddr <= 4'd0;
      r_paddr <= 6'd0;
      r_we    <= 1'b0;
    end else begin
      r_we <= w_xfer;
      if (w_start) begin
        r_num  <= w_num_clamped;
        r_kern <= 5'd0;
        r_pix  <= 6'd0;
        r_word <= 9'd0;
      end else if (w_xfer) begin
        r_data  <= bus.inData;
        r_kaddr <= r_kern[3:0];
        r_paddr <= r_pix;
        r_word  <= r_word + 9'd1;
        if (r_pix == PIX_LAST) begin
          r_pix  <= 6'd0;
          r_kern <= r_kern + 5'd1;
        end else begin
          r_pix <= r_pix + 6'd1;
        end
      end
    end
  end

  assign bus.inReady      = (r_state == S_LOAD);
  assign bus.busy         = (r_state == S_LOAD) || (r_state == S_FLUSH);
  assign bus.done         = (r_state == S_DONE);
  assign bus.sramDataIn   = r_data;
  assign bus.sramKernAddr = r_kaddr;
  assign bus.sramPixAddr  = r_paddr;
  assign bus.sramCS       = r_we;
  assign bus.sramWE       = r_we;
  assign bus.sramRD       = 1'b0;
  assign bus.sramIfmaps   = 1'b0;
  assign bus.sramPixels   = 1'b0;
  assign bus.wordCount    = r_word;

endmodule

// File: tb/tb_weight_sram_loader.sv
module tb_weight_sram_loader;

  logic Clk;
  logic Rst;
  weight_sram_loader_if bus ();

  weight_sram_loader #(.KERNELS(16), .PIXELS(25)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] k;
    logic [5:0] p;
    logic [7:0] d;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] mem [16][25];
  int         exp_k, exp_p, exp_wc;

  // SRAM model
  always @(posedge Clk) begin
    if (bus.sramCS && bus.sramWE && bus.sramKernAddr < 16 && bus.sramPixAddr < 25)
      mem[bus.sramKernAddr][bus.sramPixAddr] <= bus.sramDataIn;
  end

  // Write-port monitor
  always @(negedge Clk) begin
    check_val("cs_eq_we", 32'(bus.sramCS), 32'(bus.sramWE));
    if (bus.sramCS) begin
      check_val("tied_zero", 32'({bus.sramRD, bus.sramIfmaps, bus.sramPixels}), 32'd0);
      if (sb.size() == 0) begin
        check_val("spurious_strobe", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check_val("wr_cycle", 32'(cyc), 32'(e.cyc));
        check_val("wr_kern", 32'(bus.sramKernAddr), 32'(e.k));
        check_val("wr_pix", 32'(bus.sramPixAddr), 32'(e.p));
        check_val("wr_data", 32'(bus.sramDataIn), 32'(e.d));
        $display("write k=%0d p=%0d d=%0d", bus.sramKernAddr, bus.sramPixAddr, bus.sramDataIn);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_load(input logic [4:0] n);
    bus.start   = 1'b1;
    bus.numKern = n;
    step();
    bus.start = 1'b0;
    exp_k  = 0;
    exp_p  = 0;
    exp_wc = 0;
    check_val("start_ready", 32'(bus.inReady), 32'd1);
    check_val("start_busy", 32'(bus.busy), 32'd1);
    check_val("start_wc", 32'(bus.wordCount), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    wr_t e;
    bus.inData  = d;
    bus.inValid = 1'b1;
    check_val("ready", 32'(bus.inReady), 32'd1);
    step();
    e.cyc = cyc;
    e.k   = 4'(exp_k);
    e.p   = 6'(exp_p);
    e.d   = d;
    sb.push_back(e);
    if (exp_p == 24) begin
      exp_p = 0;
      exp_k++;
    end else begin
      exp_p++;
    end
    exp_wc++;
    check_val("wordcount", 32'(bus.wordCount), 32'(exp_wc));
    bus.inValid = 1'b0;
  endtask

  task automatic gap(input bit poke_start);
    bus.inValid = 1'b0;
    bus.start   = poke_start;
    bus.numKern = 5'd5;
    step();
    bus.start = 1'b0;
  endtask

  // Called at F+1; optionally pulses start during FLUSH, which must be ignored.
  task automatic finish_load(input int wc, input bit poke_start);
    check_val("flush_busy", 32'(bus.busy), 32'd1);
    check_val("flush_done", 32'(bus.done), 32'd0);
    check_val("flush_ready", 32'(bus.inReady), 32'd0);
    bus.start = poke_start;
    step();
    bus.start = 1'b0;
    check_val("done_pulse", 32'(bus.done), 32'd1);
    check_val("done_busy", 32'(bus.busy), 32'd0);
    step();
    check_val("idle_done", 32'(bus.done), 32'd0);
    check_val("idle_busy", 32'(bus.busy), 32'd0);
    check_val("idle_ready", 32'(bus.inReady), 32'd0);
    check_val("final_wc", 32'(bus.wordCount), 32'(wc));
    check_val("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(bus.inReady), 32'd0);
    check_val({tag, "_cs"}, 32'(bus.sramCS), 32'd0);
    check_val({tag, "_we"}, 32'(bus.sramWE), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_done"}, 32'(bus.done), 32'd0);
    check_val({tag, "_data"}, 32'(bus.sramDataIn), 32'd0);
    check_val({tag, "_kern"}, 32'(bus.sramKernAddr), 32'd0);
    check_val({tag, "_pix"}, 32'(bus.sramPixAddr), 32'd0);
    check_val({tag, "_wc"}, 32'(bus.wordCount), 32'd0);
  endtask

  initial begin
    Rst         = 1'b1;
    bus.start   = 1'b0;
    bus.numKern = 5'd0;
    bus.inData  = 8'd0;
    bus.inValid = 1'b0;
    for (int k = 0; k < 16; k++)
      for (int p = 0; p < 25; p++)
        mem[k][p] = 8'hFF;
    step();
    step();
    check_reset_outputs("reset");
    Rst = 1'b0;
    step();

    // inValid in IDLE: no ready, no strobe (monitor flags any strobe)
    bus.inValid = 1'b1;
    bus.inData  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("idle_valid_ready", 32'(bus.inReady), 32'd0);
    end
    bus.inValid = 1'b0;
    step();

    // Full 16-kernel load, back to back
    start_load(5'd16);
    for (int i = 0; i < 400; i++) send_byte(8'(i));
    finish_load(400, 1'b0);
    for (int k = 0; k < 16; k++)
      for (int p = 0; p < 25; p++)
        check_val("mem_full", 32'(mem[k][p]), 32'((25 * k + p) % 256));

    // Two kernels with alternating valid; start pokes during gaps and FLUSH
    start_load(5'd2);
    for (int i = 0; i < 50; i++) begin
      send_byte(8'hC0 ^ 8'(i));
      if (i != 49) gap(i == 10 || i == 30);
    end
    finish_load(50, 1'b1);
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 25; p++)
        check_val("mem_two", 32'(mem[k][p]), 32'(8'hC0 ^ 8'(25 * k + p)));
    for (int k = 2; k < 16; k++) begin
      check_val("mem_untouched0", 32'(mem[k][0]), 32'((25 * k) % 256));
      check_val("mem_untouched24", 32'(mem[k][24]), 32'((25 * k + 24) % 256));
    end

    // Clamping: 0 and 20 both mean 16 kernels
    start_load(5'd0);
    for (int i = 0; i < 400; i++) send_byte(8'(i + 7));
    finish_load(400, 1'b0);
    check_val("clamp0_kern", 32'(bus.sramKernAddr), 32'd15);
    check_val("clamp0_pix", 32'(bus.sramPixAddr), 32'd24);
    start_load(5'd20);
    for (int i = 0; i < 400; i++) send_byte(8'(i + 3));
    finish_load(400, 1'b0);
    check_val("clamp20_kern", 32'(bus.sramKernAddr), 32'd15);
    check_val("clamp20_pix", 32'(bus.sramPixAddr), 32'd24);

    // Reset mid-load; the beat offered on the reset edge must not be written
    start_load(5'd16);
    for (int i = 0; i < 30; i++) send_byte(8'(i));
    Rst         = 1'b1;
    bus.inValid = 1'b1;
    bus.inData  = 8'hEE;
    step();
    Rst         = 1'b0;
    bus.inValid = 1'b0;
    check_reset_outputs("midrst");
    step();
    check_val("midrst_cs2", 32'(bus.sramCS), 32'd0);
    check_val("mem_keep", 32'(mem[1][4]), 32'd29);

    // Single kernel after reset starts from (0,0)
    start_load(5'd1);
    for (int i = 0; i < 25; i++) send_byte(8'(200 + i));
    finish_load(25, 1'b0);
    for (int p = 0; p < 25; p++)
      check_val("mem_one", 32'(mem[0][p]), 32'(200 + p));
    check_val("mem_one_k1", 32'(mem[1][0]), 32'd25);

    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/weight_sram_loader.md
# weight_sram_loader

Upstream feeder for `weight_SRAM`. It accepts a stream of 8-bit kernel weights over a valid/ready handshake and generates the kernel/pixel addresses and write strobes that fill the SRAM. Weights are written kernel-major: pixel 0..24 of kernel 0, then kernel 1, and so on. It signals completion so the convolution controller can begin reads.

## Interface
- `KERNELS`, default 16: number of kernel rows in the SRAM; the maximum load count.
- `PIXELS`, default 25: weights per kernel (5x5).
- `Clk` in 1: sole clock, rising edge.
- `Rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `numKern` in 5: kernels to load, sampled on accepted `start`; 0 or >KERNELS clamps to KERNELS.
- `inData` in 8: weight byte.
- `inValid` in 1: `inData` valid.
- `inReady` out 1: loader can accept; high only in LOAD.
- `sramDataIn` out 8: to SRAM `dataIn`.
- `sramKernAddr` out 4: to SRAM `kernAddr`.
- `sramPixAddr` out 6: to SRAM `pixAddr`.
- `sramCS` out 1: chip select, high only on write cycles.
- `sramWE` out 1: write enable, equal to `sramCS`.
- `sramRD` out 1: tied 0.
- `sramIfmaps` out 1: tied 0.
- `sramPixels` out 1: tied 0.
- `busy` out 1: high in LOAD and FLUSH.
- `done` out 1: one-cycle completion pulse.
- `wordCount` out 9: weights written in the current or most recent load (0..400).

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
  - IDLE: `start`=1 goes to LOAD. On that edge, latch the clamped `numKern`, clear the pixel and kernel counters, and clear `wordCount`.
  - LOAD: `inReady`=1. A transfer is `inValid && inReady`.
  - On each transfer, register `inData` plus the current kernel/pixel counters into the SRAM output registers, and set the write strobe for the next cycle.
  - Counter update per transfer:
    - pixel wraps PIXELS-1 → 0, and kernel increments on that wrap;
    - `wordCount` increments.
  - A transfer at kernel = latched count−1 and pixel = PIXELS-1 is final and goes to FLUSH.
  - FLUSH: `inReady`=0. The final write strobe is on the outputs this cycle. Go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `inValid` low in LOAD: no strobe next cycle, and counters hold. Gaps of any length are allowed.
- `start` outside IDLE is ignored. `start` held high across DONE→IDLE starts a new load from the IDLE cycle.
- `inValid` outside LOAD is ignored, and no data is consumed.
- `Rst` mid-load:
  - all outputs and counters clear, and the state returns to IDLE;
  - a strobe pending at the reset edge is dropped;
  - SRAM contents already written are left as-is.
- Address range: `sramKernAddr` stays within 0..latched−1 and `sramPixAddr` within 0..PIXELS-1. Address 25..63 is never driven.

## Timing
- Reset values:
  - `inReady`=0, `sramCS`=0, `sramWE`=0, `busy`=0, `done`=0;
  - `sramDataIn`=0, `sramKernAddr`=0, `sramPixAddr`=0, `wordCount`=0;
  - state IDLE.
- `start` accepted at edge E: LOAD and `inReady`=1 from cycle E+1.
- Transfer at edge T: during cycle T+1, `sramCS`=`sramWE`=1 with that byte's data and address. The SRAM captures it at edge T+1. Write latency is 1 cycle, so 1 write per cycle is sustainable.
- Final transfer at edge F:
  - FLUSH during F+1, with the final strobe;
  - DONE during F+2, with `done`=1 and `busy`=0;
  - IDLE during F+3.
- Minimum full load (16 kernels, back-to-back valid): 400 transfer cycles, plus 1 start cycle, plus FLUSH and DONE.
- `wordCount` updates on the transfer edge and holds after DONE until the next accepted `start`.

## Test plan
- Reset, then `start` with `numKern`=16 and 400 back-to-back bytes with value (i mod 256):
  - SRAM[k][p] = (25k+p) mod 256;
  - `done` pulses once, 2 cycles after the last transfer;
  - `wordCount`=400.
- `numKern`=2, with `inValid` toggling 1,0,1,0:
  - 50 strobes, no strobe in cycles following an idle beat;
  - addresses (0,0)..(0,24),(1,0)..(1,24);
  - kernels 2..15 untouched.
- `numKern`=0 and `numKern`=20: both load 400 words, and `sramKernAddr` ends at 15.
- `start` pulsed during LOAD and FLUSH: ignored, and the counters are undisturbed. `inValid` high in IDLE: `inReady`=0 and no strobe.
- `Rst` after 30 transfers of a 16-kernel load:
  - next cycle all outputs 0 and IDLE, with no strobe;
  - a subsequent `numKern`=1 load writes from (0,0), and `wordCount`=25.
- Each write cycle: `sramRD`=`sramIfmaps`=`sramPixels`=0, and `sramCS`==`sramWE`.
